// File: rtl/gpio_alloc_pkg.sv
// GPIO pin allocator shared types and sizing.
// Provides the core/pin counts, the select width, the request opcodes,
// and a wrapping core-id increment used by the round-robin pointer.
package gpio_alloc_pkg;

    localparam int unsigned NUM_CORES = 4;
    localparam int unsigned NUM_PINS  = 32;
    localparam int unsigned SEL_W     = $clog2(NUM_CORES);

    localparam logic OP_CLAIM   = 1'b1;
    localparam logic OP_RELEASE = 1'b0;

    typedef logic [NUM_PINS-1:0] pin_vec_t;
    typedef logic [SEL_W-1:0]    core_id_t;

    // Core id plus one, wrapping at NUM_CORES
    function automatic core_id_t next_id(input core_id_t id);
        return (id == core_id_t'(NUM_CORES - 1)) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/gpio_pin_allocator_if.sv
// Request/response and ownership-table bus of the GPIO pin allocator.
// master: requesting cores (drive req_*, core_flush; observe grants,
//         responses and the owner table).
// slave : the allocator.
interface gpio_pin_allocator_if;
    import gpio_alloc_pkg::*;

    logic [NUM_CORES-1:0] req_valid;
    logic [NUM_CORES-1:0] req_op;
    pin_vec_t             req_mask [NUM_CORES];
    logic [NUM_CORES-1:0] core_flush;
    logic [NUM_CORES-1:0] req_ready;
    logic [NUM_CORES-1:0] resp_valid;
    logic                 resp_ok;
    pin_vec_t             resp_pins;
    core_id_t             core_select [NUM_PINS];
    pin_vec_t             pin_owned;

    modport master (
        output req_valid, req_op, req_mask, core_flush,
        input  req_ready, resp_valid, resp_ok, resp_pins, core_select, pin_owned
    );

    modport slave (
        input  req_valid, req_op, req_mask, core_flush,
        output req_ready, resp_valid, resp_ok, resp_pins, core_select, pin_owned
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester
// at or after i_ptr, wrapping. The pointer register lives in the parent.
// Ports: i_eligible (request vector), i_ptr (search start),
//        o_grant (one-hot), o_grant_id (winner index), o_any (a grant exists).
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_id,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    // Scan N positions starting at the pointer; first hit wins
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        w_idx      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = IW'((32'(i_ptr) + off) % N);
            if (!o_any && i_eligible[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/gpio_pin_allocator.sv
// GPIO pin ownership manager. Serves one claim/release per cycle through a
// round-robin arbiter and keeps a per-pin owner table; flushes drop every
// pin held by the flushing core.
// Ports: i_clk (rising edge), i_rst (synchronous, active-high),
//        bus (gpio_pin_allocator_if.slave: requests, one-hot grant,
//        registered response, core_select / pin_owned table outputs).
// Build option: GPIO_ALLOC_PARTIAL_EN -- a conflicting claim is granted the
// non-conflicting subset of its mask instead of being denied outright.
module gpio_pin_allocator
    import gpio_alloc_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    gpio_pin_allocator_if.slave   bus
);

    pin_vec_t             r_owned;
    core_id_t             r_owner [NUM_PINS];
    core_id_t             r_rr_ptr;
    logic [NUM_CORES-1:0] r_resp_valid;
    logic                 r_resp_ok;
    pin_vec_t             r_resp_pins;

    logic [NUM_CORES-1:0] w_eligible;
    logic [NUM_CORES-1:0] w_grant;
    core_id_t             w_grant_id;
    logic                 w_any;
    pin_vec_t             w_mask;
    logic                 w_op;
    pin_vec_t             w_own_k;
    pin_vec_t             w_flush_clr;
    pin_vec_t             w_conflict;
    pin_vec_t             w_set;
    pin_vec_t             w_clr;
    logic                 w_resp_ok;
    pin_vec_t             w_resp_pins;
    pin_vec_t             w_owned_nxt;

    // Flushing cores are never granted; nothing is granted in reset
    assign w_eligible = i_rst ? '0 : (bus.req_valid & ~bus.core_flush);

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign bus.req_ready = w_grant;
    assign w_mask        = bus.req_mask[w_grant_id];
    assign w_op          = bus.req_op[w_grant_id];

    // Per-pin views of pre-edge ownership: held by winner, held by a flusher
    always_comb begin
        w_own_k     = '0;
        w_flush_clr = '0;
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            w_own_k[i]     = r_owned[i] && (r_owner[i] == w_grant_id);
            w_flush_clr[i] = r_owned[i] && bus.core_flush[r_owner[i]];
        end
    end

    assign w_conflict = w_mask & r_owned & ~w_own_k;

    // Request outcome: pins to set / clear and the response payload
    always_comb begin
        w_set       = '0;
        w_clr       = '0;
        w_resp_ok   = 1'b1;
        w_resp_pins = '0;
        case (w_op)
            OP_CLAIM: begin
`ifdef GPIO_ALLOC_PARTIAL_EN
                w_set       = w_mask & ~w_conflict;
                w_resp_ok   = (w_conflict == '0);
                w_resp_pins = w_set;
`else
                if (w_conflict == '0) begin
                    w_set       = w_mask;
                    w_resp_pins = w_mask;
                end else begin
                    w_resp_ok = 1'b0;
                end
`endif
            end
            OP_RELEASE: begin
                w_clr       = w_mask & w_own_k;
                w_resp_pins = w_clr;
            end
            default: ;
        endcase
    end

    // Grant update first, then flush clears on top of it
    assign w_owned_nxt = (w_any ? ((r_owned | w_set) & ~w_clr) : r_owned) & ~w_flush_clr;

    // Owner table, round-robin pointer and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owned      <= '0;
            r_rr_ptr     <= '0;
            r_resp_valid <= '0;
            r_resp_ok    <= 1'b0;
            r_resp_pins  <= '0;
            for (int unsigned i = 0; i < NUM_PINS; i++) begin
                r_owner[i] <= '0;
            end
        end else begin
            r_owned <= w_owned_nxt;
            for (int unsigned i = 0; i < NUM_PINS; i++) begin
                if (w_any && w_set[i]) begin
                    r_owner[i] <= w_grant_id;
                end
            end
            if (w_any) begin
                r_rr_ptr <= next_id(w_grant_id);
            end
            r_resp_valid <= w_grant;
            r_resp_ok    <= w_any & w_resp_ok;
            r_resp_pins  <= w_any ? w_resp_pins : '0;
        end
    end

    // Table outputs; unowned pins report core 0
    always_comb begin
        for (int unsigned i = 0; i < NUM_PINS; i++) begin
            bus.core_select[i] = r_owned[i] ? r_owner[i] : '0;
        end
    end

    assign bus.pin_owned  = r_owned;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_ok    = r_resp_ok;
    assign bus.resp_pins  = r_resp_pins;

endmodule

// File: tb/tb_gpio_pin_allocator.sv
// Directed self-checking bench for gpio_pin_allocator. Responses are checked
// against a scoreboard queue filled when each grant is observed.
module tb_gpio_pin_allocator;
    import gpio_alloc_pkg::*;

    typedef struct packed {
        logic [NUM_CORES-1:0] core;
        logic                 ok;
        pin_vec_t             pins;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gpio_pin_allocator_if bus();

    gpio_pin_allocator dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_sel();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NUM_PINS; i++) r[SEL_W*i +: SEL_W] = bus.core_select[i];
        return r;
    endfunction

    task automatic resp_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL %s_resp: observed resp_valid 0x%0h expected scoreboard entry", tag, bus.resp_valid);
        end else begin
            e = sb.pop_front();
            chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(e.core));
            chk({tag, "_resp_ok"},    64'(bus.resp_ok),    64'(e.ok));
            chk({tag, "_resp_pins"},  64'(bus.resp_pins),  64'(e.pins));
        end
    endtask

    task automatic table_check(input string tag, input pin_vec_t owned, input logic [63:0] sel);
        chk({tag, "_pin_owned"},   64'(bus.pin_owned), 64'(owned));
        chk({tag, "_core_select"}, pack_sel(),         sel);
    endtask

    // Single-core request: drive, check grant, check response in T+1
    task automatic accept(input string tag, input core_id_t k, input logic op,
                          input pin_vec_t mask, input logic ok, input pin_vec_t pins);
        logic [NUM_CORES-1:0] oh;
        oh = NUM_CORES'(1) << k;
        tick();
        bus.req_op[k]   = op;
        bus.req_mask[k] = mask;
        bus.req_valid   = oh;
        @(negedge clk);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(oh));
        sb.push_back('{core: oh, ok: ok, pins: pins});
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        resp_check(tag);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.req_op     = '0;
        bus.core_flush = '0;
        for (int k = 0; k < NUM_CORES; k++) bus.req_mask[k] = '0;

        // Reset state, with every core requesting
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_ready",  64'(bus.req_ready),  64'h0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        table_check("rst", 32'h0, 64'h0);
        tick();
        rst           = 1'b0;
        bus.req_valid = '0;

        // Round robin from reset: all four hold disjoint claims
        for (int k = 0; k < NUM_CORES; k++) begin
            bus.req_op[k]   = OP_CLAIM;
            bus.req_mask[k] = 32'h1 << (16 + k);
        end
        bus.req_valid = '1;
        for (int k = 0; k < NUM_CORES; k++) begin
            @(negedge clk);
            if (k > 0) resp_check("rr1");
            chk("rr1_req_ready", 64'(bus.req_ready), 64'(4'b0001 << k));
            sb.push_back('{core: NUM_CORES'(4'b0001 << k), ok: 1'b1, pins: 32'h1 << (16 + k)});
            tick();
            bus.req_valid[k] = 1'b0;
        end
        @(negedge clk);
        resp_check("rr1");
        table_check("rr1", 32'h000F_0000, 64'h0000_00E4_0000_0000);

        // Pointer wrapped to 0: cores 0 and 3 release, core 0 goes first
        tick();
        bus.req_op[0] = OP_RELEASE;
        bus.req_op[3] = OP_RELEASE;
        bus.req_valid = 4'b1001;
        @(negedge clk);
        chk("rr2_first", 64'(bus.req_ready), 64'h1);
        sb.push_back('{core: 4'b0001, ok: 1'b1, pins: 32'h0001_0000});
        tick();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        resp_check("rr2");
        chk("rr2_second", 64'(bus.req_ready), 64'h8);
        sb.push_back('{core: 4'b1000, ok: 1'b1, pins: 32'h0008_0000});
        tick();
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        resp_check("rr2");
        table_check("rr2", 32'h0006_0000, 64'h0000_0024_0000_0000);

        // Fresh table
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        accept("claim_c1", 2'd1, OP_CLAIM, 32'h0000_00FF, 1'b1, 32'h0000_00FF);
        table_check("claim_c1", 32'h0000_00FF, 64'h5555);

`ifdef GPIO_ALLOC_PARTIAL_EN
        accept("conflict_c2", 2'd2, OP_CLAIM, 32'h0000_0180, 1'b0, 32'h0000_0100);
        table_check("conflict_c2", 32'h0000_01FF, 64'h2_5555);
`else
        accept("conflict_c2", 2'd2, OP_CLAIM, 32'h0000_0180, 1'b0, 32'h0);
        table_check("conflict_c2", 32'h0000_00FF, 64'h5555);
`endif

        accept("claim_c2", 2'd2, OP_CLAIM, 32'h0000_0100, 1'b1, 32'h0000_0100);
        table_check("claim_c2", 32'h0000_01FF, 64'h2_5555);

        accept("release_c1", 2'd1, OP_RELEASE, 32'h0000_0F0F, 1'b1, 32'h0000_000F);
        table_check("release_c1", 32'h0000_01F0, 64'h2_5500);

        // Flush of core 2 with its own request and a competing claim
        tick();
        bus.core_flush  = 4'b0100;
        bus.req_op[0]   = OP_CLAIM;
        bus.req_mask[0] = 32'h0000_0100;
        bus.req_op[2]   = OP_RELEASE;
        bus.req_mask[2] = 32'h0000_0100;
        bus.req_valid   = 4'b0101;
        @(negedge clk);
        chk("flush_req_ready", 64'(bus.req_ready), 64'h1);
        sb.push_back('{core: 4'b0001, ok: 1'b0, pins: 32'h0});
        tick();
        bus.core_flush = '0;
        bus.req_valid  = '0;
        @(negedge clk);
        resp_check("flush");
        table_check("flush", 32'h0000_00F0, 64'h5500);

        accept("empty_c3", 2'd3, OP_CLAIM, 32'h0, 1'b1, 32'h0);
        table_check("empty_c3", 32'h0000_00F0, 64'h5500);

        accept("reclaim_c1", 2'd1, OP_CLAIM, 32'h0000_3030, 1'b1, 32'h0000_3030);
        table_check("reclaim_c1", 32'h0000_30F0, 64'h0500_5500);

        // Reset in the cycle after a grant
        tick();
        bus.req_op[0]   = OP_CLAIM;
        bus.req_mask[0] = 32'h0000_0001;
        bus.req_valid   = 4'b0001;
        @(negedge clk);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'h1);
        sb.push_back('{core: 4'b0001, ok: 1'b1, pins: 32'h1});
        tick();
        bus.req_valid = '0;
        rst           = 1'b1;
        @(negedge clk);
        resp_check("midrst");
        tick();
        @(negedge clk);
        chk("midrst_resp_valid", 64'(bus.resp_valid), 64'h0);
        table_check("midrst", 32'h0, 64'h0);
        tick();
        rst = 1'b0;

        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_pin_allocator.md
# gpio_pin_allocator

Ownership manager for the GPIO pin bank. Cores issue claim/release requests for sets of pins. A round-robin arbiter serves one request per cycle and maintains a per-pin owner table. The table drives the per-pin `core_select` consumed by the core output arbitrator; `pin_owned` lets downstream logic force unowned pins to high-Z.

## Interface
- `NUM_CORES`, 4, number of requesting cores; select width `SEL_W = $clog2(NUM_CORES)`
- `NUM_PINS`, 32, number of GPIO pins
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_CORES  per-core request pending; held until `req_ready`
- `req_op`  in  NUM_CORES  per-core op: 1 = claim, 0 = release
- `req_mask`  in  NUM_PINS x NUM_CORES (unpacked)  per-core pin set
- `core_flush`  in  NUM_CORES  per-core force-release of all owned pins
- `req_ready`  out  NUM_CORES  one-hot grant, combinational, same cycle as accept
- `resp_valid`  out  NUM_CORES  one-hot response pulse, one cycle after accept
- `resp_ok`  out  1  result of the responded request
- `resp_pins`  out  NUM_PINS  pins actually claimed or released
- `core_select`  out  SEL_W x NUM_PINS (unpacked)  owner of each pin; 0 when unowned
- `pin_owned`  out  NUM_PINS  1 = pin has an owner

## Operation
- State per pin: `owned` bit and `owner` id. Round-robin pointer `rr_ptr` is `SEL_W` bits.
- Eligible set: `req_valid & ~core_flush`. The arbiter picks the first eligible core at or after `rr_ptr`, wrapping. It asserts `req_ready` for that core only. If any core was granted, `rr_ptr` becomes winner+1 mod NUM_CORES; otherwise `rr_ptr` holds.
- Claim by core k:
  - `conflict = mask & owned & (owner != k)`.
  - `conflict == 0`: all pins in mask become owned by k; `resp_ok=1`; `resp_pins=mask`. Pins already held by k are included.
  - `conflict != 0`: all-or-nothing denial, table unchanged; `resp_ok=0`; `resp_pins=0`.
- Release by core k:
  - Clears pins in `mask` owned by k. Pins owned by others are ignored.
  - `resp_ok=1`; `resp_pins` = pins actually cleared.
- Empty mask: `resp_ok=1`, `resp_pins=0`, no table change.
- Flush: `core_flush[k]` clears every pin owned by k at the next edge. Multiple cores may flush in the same cycle.
- A grant and flushes in the same cycle: the grant's conflict check uses pre-edge ownership. Flush clears apply after the grant update, so a pin a flushing core held is never granted to another core in that cycle.
- `core_select[i]` = `owner[i]` if `owned[i]`, else 0.

## Timing
- Reset values: `owned=0`, `owner=0`, `rr_ptr=0`, `resp_valid=0`, `resp_ok=0`, `resp_pins=0`, `core_select` all 0, `pin_owned=0`. `req_ready` is 0 during reset.
- Accept cycle T: `req_ready` is high in T. Table, `core_select` and `pin_owned` update at the T edge and are visible in T+1.
- `resp_valid`/`resp_ok`/`resp_pins` are registered and valid in T+1 only.
- Throughput: one request per cycle. A requester may drop `req_valid` after its `req_ready` cycle, or present a new request in T+1.
- Flush effect is visible in the cycle after `core_flush` is sampled.
- Reset mid-operation: an in-flight response is dropped and the table is cleared.

## Configuration
- `GPIO_ALLOC_PARTIAL_EN` defined:
  - A conflicting claim grants `mask & ~conflict` to k.
  - `resp_ok=0` if `conflict != 0`, else 1.
  - `resp_pins` = pins newly owned or already owned by k.
- Not defined: all-or-nothing claims as described in Operation.

## Structure
- `gpio_alloc_pkg`: `NUM_CORES`, `NUM_PINS`, `SEL_W`, `OP_CLAIM=1'b1`, `OP_RELEASE=1'b0`.
- Sub-module `rr_arbiter` (parameter N): inputs `eligible[N]`, `ptr`; outputs one-hot `grant`, `grant_id`, `any`. The pointer register stays in the parent.

## Test plan
- Reset, then core 1 claims `0x0000_00FF` → `req_ready=0010` in T; in T+1 `resp_valid=0010`, `resp_ok=1`, `resp_pins=0xFF`, `pin_owned=0xFF`, `core_select[0..7]=1`.
- With core 1 owning `0xFF`, core 2 claims `0x0000_0180` → `resp_ok=0`, `resp_pins=0`, table unchanged. With `GPIO_ALLOC_PARTIAL_EN`: `resp_pins=0x100`, `core_select[8]=2`.
- All four cores hold `req_valid` with disjoint claims from reset → grants in order 0,1,2,3 over four consecutive cycles. Re-raise core 0 and core 3 with `rr_ptr=0` → core 0 first.
- Core 1 releases `0x0000_0F0F` while owning `0xFF` and core 2 owns `0x100` → `resp_pins=0x0F`; `pin_owned=0x1F0`.
- Same cycle: `core_flush[2]=1`, core 2 `req_valid`, core 0 claims `0x100` owned by 2 → core 2 not granted; core 0 denied; next cycle `pin_owned[8]=0`.
- Assert `rst` in the cycle after a grant → `resp_valid=0` next cycle; `pin_owned=0`; all `core_select=0`.
